// File: rtl/afu_rsp_pkg.sv
// Shared widths and request/response records for the local-memory responder.
package afu_rsp_pkg;

    localparam int AFU_ADDR_W         = 42;
    localparam int AFU_DATA_W         = 512;
    localparam int AFU_TAG_W          = 16;
    localparam int AFU_MEM_AW         = 10;
    localparam int AFU_FIFO_AW        = 4;
    localparam int AFU_ALMFULL_MARGIN = 4;
    localparam int AFU_RD_LAT         = 2;

    typedef struct packed {
        logic [AFU_ADDR_W-1:0] addr;
        logic [AFU_TAG_W-1:0]  tag;
    } t_rd_req;

    typedef struct packed {
        logic [AFU_ADDR_W-1:0] addr;
        logic [AFU_TAG_W-1:0]  tag;
        logic [AFU_DATA_W-1:0] data;
        logic                  fence;
    } t_wr_req;

    typedef struct packed {
        logic [AFU_DATA_W-1:0] data;
        logic [AFU_TAG_W-1:0]  tag;
    } t_rd_rsp;

    typedef struct packed {
        logic [AFU_TAG_W-1:0] tag;
    } t_wr_rsp;

endpackage

// File: rtl/afu_req_fifo.sv
// Synchronous show-ahead request FIFO with registered almost-full flag.
// A push into a full FIFO is accepted only when the same cycle also pops.
module afu_req_fifo #(
    parameter type T              = logic,
    parameter int  FIFO_AW        = 4,
    parameter int  ALMFULL_MARGIN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  T                 din_i,
    input  logic             pop_i,
    output T                 dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almfull_o,
    output logic [FIFO_AW:0] occ_o
);
    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] OCC_FULL   = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] OCC_TH     = (FIFO_AW+1)'(DEPTH - ALMFULL_MARGIN);
    localparam logic [FIFO_AW:0] OCC_ONE    = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    T                   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   occ_q, occ_d;
    logic               almfull_q;
    logic               do_push, do_pop;

    assign full_o    = (occ_q == OCC_FULL);
    assign empty_o   = (occ_q == '0);
    assign do_pop    = pop_i & ~empty_o;
    assign do_push   = push_i & (~full_o | do_pop);
    assign dout_o    = mem_q[rptr_q];
    assign almfull_o = almfull_q;
    assign occ_o     = occ_q;

    // Occupancy after this cycle's push/pop
    always_comb begin
        occ_d = occ_q;
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Pointers, occupancy and almost-full register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
            almfull_q <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
            occ_q     <= occ_d;
            almfull_q <= (occ_d >= OCC_TH);
        end
    end

    // Entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/afu_mem_responder.sv
// Local line-memory responder for the core's read/write request interface.
// Optional stats counters enabled by defining AFU_RSP_STATS_EN.
module afu_mem_responder
    import afu_rsp_pkg::*;
#(
    parameter int MEM_AW         = AFU_MEM_AW,
    parameter int FIFO_AW        = AFU_FIFO_AW,
    parameter int ALMFULL_MARGIN = AFU_ALMFULL_MARGIN,
    parameter int RD_LAT         = AFU_RD_LAT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_req_valid,
    input  logic [AFU_ADDR_W-1:0] rd_req_addr,
    input  logic [AFU_TAG_W-1:0]  rd_req_tag,
    output logic                  rd_almfull,
    input  logic                  wr_req_valid,
    input  logic [AFU_ADDR_W-1:0] wr_req_addr,
    input  logic [AFU_TAG_W-1:0]  wr_req_tag,
    input  logic [AFU_DATA_W-1:0] wr_req_data,
    input  logic                  wr_req_fence,
    output logic                  wr_almfull,
    output logic                  rd_rsp_valid,
    output logic [AFU_DATA_W-1:0] rd_rsp_data,
    output logic [AFU_TAG_W-1:0]  rd_rsp_tag,
    output logic                  wr_rsp_valid,
    output logic [AFU_TAG_W-1:0]  wr_rsp_tag,
    output logic                  ovf_sticky,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt
);
    localparam int MEM_DEPTH = 1 << MEM_AW;

    t_rd_req            rd_push_req, rd_head;
    t_wr_req            wr_push_req, wr_head;
    logic               rd_full, rd_empty, wr_full, wr_empty;
    logic [FIFO_AW:0]   rd_occ_unused, wr_occ_unused;
    logic               grant_rd, grant_wr;
    logic               last_wr_q;
    logic               ovf_q;
    logic               wr_rsp_valid_q;
    t_wr_rsp            wr_rsp_q;
    logic [RD_LAT:1]    rd_vld_q;
    logic [AFU_TAG_W-1:0]  rd_tag_q  [RD_LAT:1];
    logic [AFU_DATA_W-1:0] rd_data_q [RD_LAT:1];
    logic [AFU_DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [MEM_AW-1:0]  rd_idx, wr_idx;
    logic               unused_addr_hi;

    assign rd_push_req = '{addr: rd_req_addr, tag: rd_req_tag};
    assign wr_push_req = '{addr: wr_req_addr, tag: wr_req_tag,
                           data: wr_req_data, fence: wr_req_fence};

    afu_req_fifo #(.T(t_rd_req), .FIFO_AW(FIFO_AW), .ALMFULL_MARGIN(ALMFULL_MARGIN)) u_rd_fifo (
        .clk(clk), .reset_n(reset_n),
        .push_i(rd_req_valid), .din_i(rd_push_req),
        .pop_i(grant_rd), .dout_o(rd_head),
        .full_o(rd_full), .empty_o(rd_empty), .almfull_o(rd_almfull), .occ_o(rd_occ_unused)
    );

    afu_req_fifo #(.T(t_wr_req), .FIFO_AW(FIFO_AW), .ALMFULL_MARGIN(ALMFULL_MARGIN)) u_wr_fifo (
        .clk(clk), .reset_n(reset_n),
        .push_i(wr_req_valid), .din_i(wr_push_req),
        .pop_i(grant_wr), .dout_o(wr_head),
        .full_o(wr_full), .empty_o(wr_empty), .almfull_o(wr_almfull), .occ_o(wr_occ_unused)
    );

    // Memory only sees the low MEM_AW address bits; upper bits alias
    assign rd_idx = rd_head.addr[MEM_AW-1:0];
    assign wr_idx = wr_head.addr[MEM_AW-1:0];
    assign unused_addr_hi = ^{rd_head.addr[AFU_ADDR_W-1:MEM_AW], wr_head.addr[AFU_ADDR_W-1:MEM_AW],
                              rd_occ_unused, wr_occ_unused};

    // One pop per cycle; alternate when both queues hold work
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (!rd_empty && (wr_empty || last_wr_q)) grant_rd = 1'b1;
        else if (!wr_empty)                        grant_wr = 1'b1;
    end

    // Arbiter history, overflow flag and write acks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_wr_q      <= 1'b1;
            ovf_q          <= 1'b0;
            wr_rsp_valid_q <= 1'b0;
            wr_rsp_q       <= '0;
        end else begin
            if (grant_rd || grant_wr) last_wr_q <= grant_wr;
            if ((rd_req_valid && rd_full && !grant_rd) || (wr_req_valid && wr_full && !grant_wr))
                ovf_q <= 1'b1;
            wr_rsp_valid_q <= grant_wr;
            wr_rsp_q.tag   <= grant_wr ? wr_head.tag : '0;
        end
    end

    // Single-port line memory; read data then rides the latency pipe
    always_ff @(posedge clk) begin
        if (grant_wr && !wr_head.fence) mem_q[wr_idx] <= wr_head.data;
        if (grant_rd) rd_data_q[1] <= mem_q[rd_idx];
        for (int k = 2; k <= RD_LAT; k++) rd_data_q[k] <= rd_data_q[k-1];
    end

    // Read valid/tag pipe; reset flushes in-flight reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q <= '0;
            for (int k = 1; k <= RD_LAT; k++) rd_tag_q[k] <= '0;
        end else begin
            rd_vld_q[1] <= grant_rd;
            rd_tag_q[1] <= grant_rd ? rd_head.tag : '0;
            for (int k = 2; k <= RD_LAT; k++) begin
                rd_vld_q[k] <= rd_vld_q[k-1];
                rd_tag_q[k] <= rd_tag_q[k-1];
            end
        end
    end

    assign rd_rsp_valid = rd_vld_q[RD_LAT];
    assign rd_rsp_tag   = rd_vld_q[RD_LAT] ? rd_tag_q[RD_LAT]  : '0;
    assign rd_rsp_data  = rd_vld_q[RD_LAT] ? rd_data_q[RD_LAT] : '0;
    assign wr_rsp_valid = wr_rsp_valid_q;
    assign wr_rsp_tag   = wr_rsp_q.tag;
    assign ovf_sticky   = ovf_q;

`ifdef AFU_RSP_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    // Completion counters, wrap naturally at 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_q + 32'(rd_rsp_valid);
            wr_cnt_q <= wr_cnt_q + 32'(wr_rsp_valid);
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_afu_mem_responder.sv
// Directed self-checking bench for afu_mem_responder (default parameters).
module tb_afu_mem_responder;
    import afu_rsp_pkg::*;

    localparam int RD_LAT = AFU_RD_LAT;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  rd_req_valid;
    logic [AFU_ADDR_W-1:0] rd_req_addr;
    logic [AFU_TAG_W-1:0]  rd_req_tag;
    logic                  rd_almfull;
    logic                  wr_req_valid;
    logic [AFU_ADDR_W-1:0] wr_req_addr;
    logic [AFU_TAG_W-1:0]  wr_req_tag;
    logic [AFU_DATA_W-1:0] wr_req_data;
    logic                  wr_req_fence;
    logic                  wr_almfull;
    logic                  rd_rsp_valid;
    logic [AFU_DATA_W-1:0] rd_rsp_data;
    logic [AFU_TAG_W-1:0]  rd_rsp_tag;
    logic                  wr_rsp_valid;
    logic [AFU_TAG_W-1:0]  wr_rsp_tag;
    logic                  ovf_sticky;
    logic [31:0]           rd_cnt, wr_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [AFU_DATA_W-1:0] d_a5, d_3c, d_77, d_d1, d_d2, d_ff, d_99;

    always #5 clk = ~clk;

    afu_mem_responder dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag),
        .rd_almfull(rd_almfull),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_tag(wr_req_tag),
        .wr_req_data(wr_req_data), .wr_req_fence(wr_req_fence), .wr_almfull(wr_almfull),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_tag(rd_rsp_tag),
        .wr_rsp_valid(wr_rsp_valid), .wr_rsp_tag(wr_rsp_tag),
        .ovf_sticky(ovf_sticky), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_tag = '0;
        wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_tag = '0;
        wr_req_data  = '0;   wr_req_fence = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        vec_cnt++;
        if ({rd_almfull, wr_almfull, rd_rsp_valid, wr_rsp_valid, ovf_sticky} !== 5'b0)
            begin err_cnt++; $display("FAIL reset_flags got %b want 00000", {rd_almfull, wr_almfull, rd_rsp_valid, wr_rsp_valid, ovf_sticky}); end
        vec_cnt++;
        if (rd_rsp_data !== '0 || rd_rsp_tag !== '0 || wr_rsp_tag !== '0)
            begin err_cnt++; $display("FAIL reset_rsp got tag %h/%h want 0", rd_rsp_tag, wr_rsp_tag); end
        vec_cnt++;
        if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0)
            begin err_cnt++; $display("FAIL reset_cnt got %0d/%0d want 0/0", rd_cnt, wr_cnt); end
        reset_n = 1'b1;
        tick();
    endtask

    // Write then read the same line
    task automatic test_wr_then_rd();
        apply_reset();
        wr_req_valid = 1'b1; wr_req_addr = 42'h5; wr_req_tag = 16'h11; wr_req_data = d_a5;
        tick();
        wr_req_valid = 1'b0;
        tick();
        vec_cnt++;
        if (wr_rsp_valid !== 1'b1 || wr_rsp_tag !== 16'h11)
            begin err_cnt++; $display("FAIL t1_wr_ack got v=%b tag=%h want v=1 tag=0011", wr_rsp_valid, wr_rsp_tag); end
        rd_req_valid = 1'b1; rd_req_addr = 42'h5; rd_req_tag = 16'h22;
        tick();
        rd_req_valid = 1'b0;
        for (int i = 1; i < RD_LAT; i++) begin
            tick();
            vec_cnt++;
            if (rd_rsp_valid !== 1'b0)
                begin err_cnt++; $display("FAIL t1_rd_early got v=%b want 0", rd_rsp_valid); end
        end
        tick();
        vec_cnt++;
        if (rd_rsp_valid !== 1'b1 || rd_rsp_tag !== 16'h22 || rd_rsp_data !== d_a5)
            begin err_cnt++; $display("FAIL t1_rd_rsp got v=%b tag=%h data=%h want v=1 tag=0022 data=a5..", rd_rsp_valid, rd_rsp_tag, rd_rsp_data); end
    endtask

    // Read and write pushed together; read wins after reset and sees old data
    task automatic test_simultaneous();
        apply_reset();
        rd_req_valid = 1'b1; rd_req_addr = 42'h5; rd_req_tag = 16'h33;
        wr_req_valid = 1'b1; wr_req_addr = 42'h5; wr_req_tag = 16'h44; wr_req_data = d_3c;
        tick();
        idle_inputs();
        tick();
        vec_cnt++;
        if (rd_rsp_valid !== 1'b0 || wr_rsp_valid !== 1'b0)
            begin err_cnt++; $display("FAIL t2_early got rd=%b wr=%b want 0 0", rd_rsp_valid, wr_rsp_valid); end
        tick();
        vec_cnt++;
        if (rd_rsp_valid !== 1'b1 || rd_rsp_tag !== 16'h33 || rd_rsp_data !== d_a5)
            begin err_cnt++; $display("FAIL t2_rd_old got v=%b tag=%h data=%h want v=1 tag=0033 data=a5..", rd_rsp_valid, rd_rsp_tag, rd_rsp_data); end
        vec_cnt++;
        if (wr_rsp_valid !== 1'b1 || wr_rsp_tag !== 16'h44)
            begin err_cnt++; $display("FAIL t2_wr_overlap got v=%b tag=%h want v=1 tag=0044", wr_rsp_valid, wr_rsp_tag); end
        rd_req_valid = 1'b1; rd_req_addr = 42'h5; rd_req_tag = 16'h35;
        tick();
        rd_req_valid = 1'b0;
        for (int i = 0; i < RD_LAT; i++) tick();
        vec_cnt++;
        if (rd_rsp_valid !== 1'b1 || rd_rsp_tag !== 16'h35 || rd_rsp_data !== d_3c)
            begin err_cnt++; $display("FAIL t2_rd_new got v=%b tag=%h data=%h want v=1 tag=0035 data=3c..", rd_rsp_valid, rd_rsp_tag, rd_rsp_data); end
    endtask

    // Reads and writes pushed every cycle: reads drain at half rate and fill up
    task automatic test_almfull_ovf();
        apply_reset();
        for (int n = 1; n <= 33; n++) begin
            rd_req_valid = 1'b1; rd_req_addr = 42'(n); rd_req_tag = 16'(n);
            wr_req_valid = (n >= 2); wr_req_addr = 42'(16'h100 + n); wr_req_tag = 16'(16'h200 + n);
            wr_req_data  = AFU_DATA_W'(n);
            tick();
            if (n == 22) begin
                vec_cnt++;
                if (rd_almfull !== 1'b0) begin err_cnt++; $display("FAIL t3_rd_almfull_11 got %b want 0", rd_almfull); end
            end
            if (n == 23) begin
                vec_cnt++;
                if (rd_almfull !== 1'b1) begin err_cnt++; $display("FAIL t3_rd_almfull_12 got %b want 1", rd_almfull); end
                vec_cnt++;
                if (wr_almfull !== 1'b0) begin err_cnt++; $display("FAIL t3_wr_almfull_11 got %b want 0", wr_almfull); end
            end
            if (n == 24) begin
                vec_cnt++;
                if (wr_almfull !== 1'b1) begin err_cnt++; $display("FAIL t3_wr_almfull_12 got %b want 1", wr_almfull); end
            end
            if (n == 32) begin
                vec_cnt++;
                if (ovf_sticky !== 1'b0) begin err_cnt++; $display("FAIL t3_no_ovf got %b want 0", ovf_sticky); end
            end
            if (n == 33) begin
                vec_cnt++;
                if (ovf_sticky !== 1'b1) begin err_cnt++; $display("FAIL t3_ovf got %b want 1", ovf_sticky); end
            end
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();
        vec_cnt++;
        if (ovf_sticky !== 1'b1) begin err_cnt++; $display("FAIL t3_ovf_sticky got %b want 1", ovf_sticky); end
    endtask

    // Fence between two writes: acks in order, memory untouched by fence
    task automatic test_fence();
        apply_reset();
        wr_req_valid = 1'b1; wr_req_addr = 42'h30; wr_req_tag = 16'h01; wr_req_data = d_77;
        tick();
        wr_req_valid = 1'b0;
        tick();
        wr_req_valid = 1'b1; wr_req_addr = 42'h20; wr_req_tag = 16'hA1; wr_req_data = d_d1; wr_req_fence = 1'b0;
        tick();
        wr_req_addr = 42'h30; wr_req_tag = 16'hFE; wr_req_data = d_ff; wr_req_fence = 1'b1;
        tick();
        vec_cnt++;
        if (wr_rsp_valid !== 1'b1 || wr_rsp_tag !== 16'hA1)
            begin err_cnt++; $display("FAIL t4_ack_a got v=%b tag=%h want v=1 tag=00a1", wr_rsp_valid, wr_rsp_tag); end
        wr_req_addr = 42'h21; wr_req_tag = 16'hB2; wr_req_data = d_d2; wr_req_fence = 1'b0;
        tick();
        vec_cnt++;
        if (wr_rsp_valid !== 1'b1 || wr_rsp_tag !== 16'hFE)
            begin err_cnt++; $display("FAIL t4_ack_fence got v=%b tag=%h want v=1 tag=00fe", wr_rsp_valid, wr_rsp_tag); end
        idle_inputs();
        tick();
        vec_cnt++;
        if (wr_rsp_valid !== 1'b1 || wr_rsp_tag !== 16'hB2)
            begin err_cnt++; $display("FAIL t4_ack_b got v=%b tag=%h want v=1 tag=00b2", wr_rsp_valid, wr_rsp_tag); end
        rd_req_valid = 1'b1; rd_req_addr = 42'h30; rd_req_tag = 16'h3A;
        tick();
        rd_req_valid = 1'b0;
        for (int i = 0; i < RD_LAT; i++) tick();
        vec_cnt++;
        if (rd_rsp_valid !== 1'b1 || rd_rsp_tag !== 16'h3A || rd_rsp_data !== d_77)
            begin err_cnt++; $display("FAIL t4_fence_mem got v=%b tag=%h data=%h want v=1 tag=003a data=77..", rd_rsp_valid, rd_rsp_tag, rd_rsp_data); end
    endtask

    // Reset with reads in flight: nothing leaks out afterwards
    task automatic test_reset_inflight();
        logic seen;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            rd_req_valid = 1'b1; rd_req_addr = 42'h5; rd_req_tag = 16'(16'h51 + i);
            tick();
        end
        idle_inputs();
        reset_n = 1'b0;
        #1;
        vec_cnt++;
        if (rd_rsp_valid !== 1'b0 || rd_rsp_tag !== '0 || rd_rsp_data !== '0)
            begin err_cnt++; $display("FAIL t5_async_clear got v=%b tag=%h want 0", rd_rsp_valid, rd_rsp_tag); end
        tick();
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rd_rsp_valid !== 1'b0) seen = 1'b1;
        end
        vec_cnt++;
        if (seen !== 1'b0) begin err_cnt++; $display("FAIL t5_leak got rsp after reset want none"); end
        rd_req_valid = 1'b1; rd_req_addr = 42'h5; rd_req_tag = 16'h5A;
        tick();
        rd_req_valid = 1'b0;
        for (int i = 1; i < RD_LAT; i++) tick();
        vec_cnt++;
        if (rd_rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL t5_early got v=%b want 0", rd_rsp_valid); end
        tick();
        vec_cnt++;
        if (rd_rsp_valid !== 1'b1 || rd_rsp_tag !== 16'h5A || rd_rsp_data !== d_3c)
            begin err_cnt++; $display("FAIL t5_first_rd got v=%b tag=%h data=%h want v=1 tag=005a data=3c..", rd_rsp_valid, rd_rsp_tag, rd_rsp_data); end
    endtask

    // Address aliasing above MEM_AW bits, plus stats counters
    task automatic test_alias_stats();
        logic [31:0] exp_cnt;
`ifdef AFU_RSP_STATS_EN
        exp_cnt = 32'd1;
`else
        exp_cnt = 32'd0;
`endif
        apply_reset();
        wr_req_valid = 1'b1; wr_req_addr = 42'h400; wr_req_tag = 16'h61; wr_req_data = d_99;
        tick();
        wr_req_valid = 1'b0;
        tick();
        vec_cnt++;
        if (wr_rsp_valid !== 1'b1 || wr_rsp_tag !== 16'h61)
            begin err_cnt++; $display("FAIL t6_wr_ack got v=%b tag=%h want v=1 tag=0061", wr_rsp_valid, wr_rsp_tag); end
        rd_req_valid = 1'b1; rd_req_addr = 42'h0; rd_req_tag = 16'h62;
        tick();
        rd_req_valid = 1'b0;
        for (int i = 0; i < RD_LAT; i++) tick();
        vec_cnt++;
        if (rd_rsp_valid !== 1'b1 || rd_rsp_tag !== 16'h62 || rd_rsp_data !== d_99)
            begin err_cnt++; $display("FAIL t6_alias got v=%b tag=%h data=%h want v=1 tag=0062 data=99..", rd_rsp_valid, rd_rsp_tag, rd_rsp_data); end
        tick();
        vec_cnt++;
        if (rd_cnt !== exp_cnt || wr_cnt !== exp_cnt)
            begin err_cnt++; $display("FAIL t6_stats got rd=%0d wr=%0d want %0d/%0d", rd_cnt, wr_cnt, exp_cnt, exp_cnt); end
    endtask

    initial begin
        d_a5 = {64{8'hA5}}; d_3c = {64{8'h3C}}; d_77 = {64{8'h77}};
        d_d1 = {64{8'hD1}}; d_d2 = {64{8'hD2}}; d_ff = {64{8'hFF}}; d_99 = {64{8'h99}};
        idle_inputs();
        reset_n = 1'b0;
        test_reset();
        test_wr_then_rd();
        test_simultaneous();
        test_almfull_ovf();
        test_fence();
        test_reset_inflight();
        test_alias_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
